// File: rtl/des_pkg.sv
// Shared DES definitions: engine states, round count, the FIPS 46-3
// permutation and S-box tables, and helpers that apply them.
// Table entries use DES numbering, where bit 1 is the MSB of each bus.
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NUM_ROUNDS = 16;

    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TABLE [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is stored row-major: entry index = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [63:0] ip_permute(input logic [63:0] d);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            res[63 - i] = d[64 - IP_TABLE[i]];
        end
        return res;
    endfunction

    function automatic logic [63:0] fp_permute(input logic [63:0] d);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            res[63 - i] = d[64 - FP_TABLE[i]];
        end
        return res;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] d);
        logic [47:0] res;
        res = '0;
        for (int i = 0; i < 48; i++) begin
            res[47 - i] = d[32 - E_TABLE[i]];
        end
        return res;
    endfunction

    function automatic logic [31:0] p_permute(input logic [31:0] d);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            res[31 - i] = d[32 - P_TABLE[i]];
        end
        return res;
    endfunction

    // Row comes from the outer bits (1 and 6), column from the inner four.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] g);
        return 4'(SBOX[box][{g[5], g[0], g[4:1]}]);
    endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K) = P(S1..S8(E(R) xor K)), purely combinational.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] mixed;
    logic [31:0] sbox_out;

    // Expand, mix in the subkey, then squeeze each 6-bit group through its S-box.
    always_comb begin
        mixed    = e_expand(r) ^ k;
        sbox_out = '0;
        for (int b = 0; b < 8; b++) begin
            sbox_out[31 - 4*b -: 4] = sbox_lookup(b, mixed[47 - 6*b -: 6]);
        end
    end

    assign f = p_permute(sbox_out);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES block engine: one Feistel round per consumed subkey.
// Encrypt or decrypt is decided entirely by the subkey order fed in.
module des_round_engine
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [47:0] key_in,
    output logic [4:0]  round_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    state_t      state;
    state_t      state_next;
    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [31:0] f_val;
    logic [4:0]  round_cnt;
    logic        accept;
    logic        consume;

    des_f u_f (
        .r (r_reg),
        .k (key_in),
        .f (f_val)
    );

    assign accept  = in_valid & in_ready;
    assign consume = key_valid & key_ready;

    // State register; reset abandons any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; ready signals depend on state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        key_ready  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                key_ready = 1'b1;
                if (key_valid && (round_cnt == LAST_ROUND)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Feistel halves and round counter; everything holds while no key arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_reg     <= '0;
            r_reg     <= '0;
            round_cnt <= '0;
        end else if (accept) begin
            {l_reg, r_reg} <= ip_permute(in_data);
            round_cnt      <= 5'd1;
        end else if (consume) begin
            l_reg     <= r_reg;
            r_reg     <= l_reg ^ f_val;
            round_cnt <= round_cnt + 5'd1;
        end
    end

    // The final swap is folded into the output by presenting R16 ahead of L16.
    assign round_idx = (state == ST_ROUND) ? round_cnt : 5'd0;
    assign out_data  = out_valid ? fp_permute({r_reg, l_reg}) : 64'h0;

endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine using the classic
// key 133457799BBCDFF1 / plaintext 0123456789ABCDEF vector.
module tb_des_round_engine;

    localparam logic [63:0] PLAIN  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CIPHER = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'h0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [47:0] key_in = 48'h0;
    logic [4:0]  round_idx;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int out_count = 0;
    int out_hs_edge = 0;

    logic [63:0] exp_q [$];
    logic [47:0] ks [1:16];

    logic key_gap_mode = 1'b0;
    logic next_dir = 1'b0;
    logic cur_dir = 1'b0;
    int   gap_left = 0;

    des_round_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .round_idx (round_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Standard subkeys K1..K16 for key 133457799BBCDFF1.
    initial begin
        ks[1]  = 48'b000110_110000_001011_101111_111111_000111_000001_110010;
        ks[2]  = 48'b011110_011010_111011_011001_110110_111100_100111_100101;
        ks[3]  = 48'b010101_011111_110010_001010_010000_101100_111110_011001;
        ks[4]  = 48'b011100_101010_110111_010110_110110_110011_010100_011101;
        ks[5]  = 48'b011111_001110_110000_000111_111010_110101_001110_101000;
        ks[6]  = 48'b011000_111010_010100_111110_010100_000111_101100_101111;
        ks[7]  = 48'b111011_001000_010010_110111_111101_100001_100010_111100;
        ks[8]  = 48'b111101_111000_101000_111010_110000_010011_101111_111011;
        ks[9]  = 48'b111000_001101_101111_101011_111011_011110_011110_000001;
        ks[10] = 48'b101100_011111_001101_000111_101110_100100_011001_001111;
        ks[11] = 48'b001000_010101_111111_010011_110111_101101_001110_000110;
        ks[12] = 48'b011101_010111_000111_110101_100101_000110_011111_101001;
        ks[13] = 48'b100101_111100_010111_010001_111110_101011_101001_000001;
        ks[14] = 48'b010111_110100_001110_110111_111100_101110_011100_111010;
        ks[15] = 48'b101111_111001_000110_001101_001111_010011_111100_001010;
        ks[16] = 48'b110010_110011_110110_001011_000011_100001_011111_110101;
    end

    // Upstream key-schedule model: serves the subkey for round_idx, optionally with random gaps.
    always begin
        logic        hs;
        logic [63:0] rnd;
        int          ri;
        @(negedge clk);
        hs = key_valid && key_ready;
        @(posedge clk);
        #2;
        ri = int'(round_idx);
        if (ri == 0) cur_dir = next_dir;
        if (hs && key_gap_mode) gap_left = $urandom_range(0, 5);
        if (!key_gap_mode) begin
            key_valid = 1'b1;
        end else if (ri == 0) begin
            key_valid = 1'b0;
        end else if (gap_left == 0) begin
            key_valid = 1'b1;
        end else begin
            key_valid = 1'b0;
            gap_left--;
        end
        rnd = {$urandom(), $urandom()};
        if (ri >= 1 && ri <= 16) key_in = cur_dir ? ks[17 - ri] : ks[ri];
        else key_in = rnd[47:0];
    end

    // Output scoreboard: pops on every output handshake and checks idle output is zero.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (out_valid !== 1'b1) begin
            checks++;
            if (out_data !== 64'h0) begin
                failures++;
                $display("[TB] FAIL out_data_idle got=%h required=%h", out_data, 64'h0);
            end
        end else if (out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL out_unexpected got=%h required=no_output", out_data);
            end else begin
                exp = exp_q.pop_front();
                if (out_data !== exp) begin
                    failures++;
                    $display("[TB] FAIL out_data got=%h required=%h", out_data, exp);
                end
            end
            out_count++;
            out_hs_edge = cyc + 1;
        end
    end

    task automatic send_block(input logic [63:0] data, input logic dir,
                              input logic [63:0] expected, output int acc_edge);
        logic        acc;
        logic [63:0] rnd;
        int          b;
        next_dir = dir;
        in_data  = data;
        in_valid = 1'b1;
        exp_q.push_back(expected);
        acc = 1'b0;
        b   = 0;
        while (!acc && b < 200) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            b++;
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("[TB] FAIL accept_timeout got=0 required=1");
        end
        acc_edge = cyc;
        in_valid = 1'b0;
        rnd      = {$urandom(), $urandom()};
        in_data  = rnd;
    endtask

    task automatic wait_output(input int target);
        int b;
        b = 0;
        while (out_count < target && b < 400) begin
            @(posedge clk);
            #1;
            b++;
        end
        checks++;
        if (out_count < target) begin
            failures++;
            $display("[TB] FAIL out_timeout got=%0d required=%0d", out_count, target);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready got=%b required=1", in_ready); end
        checks++; if (key_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_key_ready got=%b required=0", key_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b required=0", out_valid); end
        checks++; if (round_idx !== 5'd0) begin failures++; $display("[TB] FAIL rst_round_idx got=%0d required=0", round_idx); end
        checks++; if (out_data !== 64'h0) begin failures++; $display("[TB] FAIL rst_out_data got=%h required=0", out_data); end
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_encrypt();
        int acc;
        int start;
        $display("[TB] test_encrypt");
        out_ready    = 1'b0;
        key_gap_mode = 1'b0;
        start        = out_count;
        send_block(PLAIN, 1'b0, CIPHER, acc);
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                checks++; if (dut.l_reg !== 32'hF0AAF0AA) begin failures++; $display("[TB] FAIL round1_l got=%h required=F0AAF0AA", dut.l_reg); end
                checks++; if (dut.r_reg !== 32'hEF4A6544) begin failures++; $display("[TB] FAIL round1_r got=%h required=EF4A6544", dut.r_reg); end
                checks++; if (round_idx !== 5'd2) begin failures++; $display("[TB] FAIL round1_idx got=%0d required=2", round_idx); end
            end
            if (n == 15) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL early_out_valid got=%b required=0", out_valid); end
                checks++; if (round_idx !== 5'd16) begin failures++; $display("[TB] FAIL round15_idx got=%0d required=16", round_idx); end
            end
            if (n == 16) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL edge16_out_valid got=%b required=1", out_valid); end
                checks++; if (out_data !== CIPHER) begin failures++; $display("[TB] FAIL edge16_out_data got=%h required=%h", out_data, CIPHER); end
                checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL done_in_ready got=%b required=0", in_ready); end
                checks++; if (key_ready !== 1'b0) begin failures++; $display("[TB] FAIL done_key_ready got=%b required=0", key_ready); end
                checks++; if (round_idx !== 5'd0) begin failures++; $display("[TB] FAIL done_round_idx got=%0d required=0", round_idx); end
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_output(start + 1);
    endtask

    task automatic test_decrypt();
        int acc;
        int start;
        $display("[TB] test_decrypt");
        out_ready = 1'b1;
        start     = out_count;
        send_block(CIPHER, 1'b1, PLAIN, acc);
        wait_output(start + 1);
    endtask

    task automatic test_key_gaps();
        int acc;
        int start;
        int exp_idx;
        int b;
        $display("[TB] test_key_gaps");
        key_gap_mode = 1'b1;
        out_ready    = 1'b1;
        start        = out_count;
        send_block(PLAIN, 1'b0, CIPHER, acc);
        exp_idx = 1;
        b = 0;
        while (exp_idx <= 16 && b < 300) begin
            @(negedge clk);
            b++;
            checks++;
            if (round_idx !== 5'(exp_idx)) begin
                failures++;
                $display("[TB] FAIL gap_round_idx got=%0d required=%0d", round_idx, exp_idx);
            end
            if (key_valid && key_ready) exp_idx++;
        end
        checks++;
        if (exp_idx <= 16) begin
            failures++;
            $display("[TB] FAIL gap_timeout got=%0d required=17", exp_idx);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL gap_out_valid got=%b required=1", out_valid); end
        wait_output(start + 1);
        key_gap_mode = 1'b0;
    endtask

    task automatic test_output_stall();
        int   acc;
        int   start;
        int   b;
        logic got;
        $display("[TB] test_output_stall");
        out_ready = 1'b0;
        start     = out_count;
        send_block(PLAIN, 1'b0, CIPHER, acc);
        b = 0;
        while (out_valid !== 1'b1 && b < 40) begin
            @(posedge clk);
            #1;
            b++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_wait got=%b required=1", out_valid); end
        next_dir = 1'b1;
        in_data  = CIPHER;
        in_valid = 1'b1;
        exp_q.push_back(PLAIN);
        repeat (10) begin
            @(negedge clk);
            checks++; if (out_data !== CIPHER) begin failures++; $display("[TB] FAIL stall_out_data got=%h required=%h", out_data, CIPHER); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready got=%b required=0", in_ready); end
            checks++; if (round_idx !== 5'd0) begin failures++; $display("[TB] FAIL stall_accepted got=%0d required=0", round_idx); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        got = 1'b0;
        b = 0;
        while (!got && b < 20) begin
            @(negedge clk);
            got = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            b++;
        end
        in_valid = 1'b0;
        acc = cyc;
        checks++;
        if (!got || acc != out_hs_edge + 1) begin
            failures++;
            $display("[TB] FAIL stall_accept_edge got=%0d required=%0d", acc, out_hs_edge + 1);
        end
        wait_output(start + 2);
    endtask

    task automatic test_reset_mid();
        int start;
        int b;
        $display("[TB] test_reset_mid");
        out_ready = 1'b1;
        start     = out_count;
        begin
            int acc;
            send_block(PLAIN, 1'b0, CIPHER, acc);
        end
        b = 0;
        while (round_idx !== 5'd7 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        checks++; if (round_idx !== 5'd7) begin failures++; $display("[TB] FAIL mid_reach_round7 got=%0d required=7", round_idx); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_ready got=%b required=1", in_ready); end
        checks++; if (key_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_key_ready got=%b required=0", key_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_out_valid got=%b required=0", out_valid); end
        checks++; if (round_idx !== 5'd0) begin failures++; $display("[TB] FAIL mid_round_idx got=%0d required=0", round_idx); end
        checks++; if (dut.l_reg !== 32'h0) begin failures++; $display("[TB] FAIL mid_l_reg got=%h required=0", dut.l_reg); end
        exp_q.delete();
        @(posedge clk);
        #1;
        next_dir = 1'b1;
        in_data  = CIPHER;
        in_valid = 1'b1;
        exp_q.push_back(PLAIN);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (round_idx !== 5'd1) begin failures++; $display("[TB] FAIL first_edge_accept got=%0d required=1", round_idx); end
        in_valid = 1'b0;
        wait_output(start + 1);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (out_count !== start + 1) begin failures++; $display("[TB] FAIL abandoned_output got=%0d required=%0d", out_count, start + 1); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int prev;
        int start;
        $display("[TB] test_back_to_back");
        out_ready    = 1'b1;
        key_gap_mode = 1'b0;
        start        = out_count;
        prev         = 0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) send_block(PLAIN, 1'b0, CIPHER, acc);
            else            send_block(CIPHER, 1'b1, PLAIN, acc);
            if (i > 0) begin
                checks++;
                if (acc - prev != 18) begin
                    failures++;
                    $display("[TB] FAIL b2b_interval got=%0d required=18", acc - prev);
                end
            end
            prev = acc;
        end
        wait_output(start + 4);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_key_gaps();
        test_output_stall();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_round_engine.md
DES_ROUND_ENGINE -- requirements
Module: des_round_engine

Interface
REQ-001 SHALL have no parameters; all widths are fixed by DES, with bit 1 as the MSB on every bus.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_data is valid.
REQ-005 in_ready  output  1  engine accepts a block; high only in IDLE.
REQ-006 in_data  input  64  input block (plaintext or ciphertext).
REQ-007 key_valid  input  1  key_in holds the subkey for round round_idx.
REQ-008 key_ready  output  1  engine consumes a subkey this cycle; high only in ROUND.
REQ-009 key_in  input  48  subkey K_n as produced by the key-schedule stage.
REQ-010 round_idx  output  5  next round to execute (1..16); 0 outside ROUND.
REQ-011 out_valid  output  1  out_data holds a finished block; high only in DONE.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  64  FP(R16||L16); 0 when out_valid is low.

Function
REQ-014 SHALL implement states IDLE, ROUND and DONE.
REQ-015 IDLE: in_valid&in_ready at an edge SHALL load {L,R} <= IP(in_data), set round counter to 1 and enter ROUND.
REQ-016 ROUND: each edge with key_valid&key_ready SHALL compute L <= R and R <= L xor f(R,key_in), then increment the counter.
REQ-017 ROUND with key_valid low SHALL hold all state; stalls of any length are legal.
REQ-018 The edge consuming round 16 SHALL enter DONE; the swap is not applied (the output uses R16||L16).
REQ-019 Latency with key_valid held high: acceptance at edge 0, rounds at edges 1..16, out_valid high from edge 16 until the output handshake.
REQ-020 DONE: out_data SHALL be stable while out_valid&!out_ready; an edge with out_ready high SHALL return to IDLE.
REQ-021 in_ready is low in DONE, so no new block is accepted in the handshake cycle; the next acceptance is no earlier than 1 cycle after the return to IDLE.
REQ-022 f SHALL be P(S1..S8(E(R) xor K)), with the standard FIPS 46-3 tables; S-box row is bits 1,6 and column is bits 2..5 of each 6-bit group.
REQ-023 The engine SHALL be encrypt/decrypt agnostic; direction is set solely by the subkey order supplied upstream (K1..K16 or K16..K1).
REQ-024 key_ready SHALL NOT depend combinationally on key_valid, and in_ready SHALL NOT depend on in_valid.
REQ-025 key_in is ignored outside ROUND; in_data is ignored outside IDLE.

Reset
REQ-026 While rst_n is low: state = IDLE, L = R = 0, counter = 0, in_ready = 1, key_ready = 0, out_valid = 0, out_data = 0, round_idx = 0.
REQ-027 Reset asserted mid-operation SHALL abandon the block immediately, with no output produced.
REQ-028 After rst_n rises, the first edge SHALL already be able to accept a block.

Structure
REQ-029 Package des_pkg SHALL hold the IP, FP, E and P permutation tables, the S1..S8 tables, the state enum, and the round count constant 16.
REQ-030 The f function SHALL be a separate combinational sub-module des_f (inputs R[32] and K[48], output [32]), instantiated once.

Verification
REQ-031 key 133457799BBCDFF1: supply the standard subkeys K1..K16 (K1 = 1B02EFFC7072) with key_valid held high and in_data = 0123456789ABCDEF -> after edge 1 L = F0AAF0AA and R = EF4A6544; out_data = 85E813540F0AB405 with out_valid high at edge 16.
REQ-032 Decrypt: in_data = 85E813540F0AB405 with subkeys in order K16..K1 -> out_data = 0123456789ABCDEF.
REQ-033 Random key_valid gaps of 0-5 cycles between rounds -> same ciphertext as REQ-031; round_idx advances only on handshakes.
REQ-034 out_ready held low for 10 cycles -> out_data stable and in_ready low; the next block is accepted only after the output handshake.
REQ-035 rst_n pulsed low at round 7 -> all outputs go to reset values asynchronously; a following block encrypts correctly.
REQ-036 Back-to-back blocks with out_ready and key_valid held high -> a new acceptance every 18 cycles, each result correct.
